onehot_seq_fsm: RTL and testbench
=================================

Name: onehot_seq_fsm

Overview:
- Registered, parametrised successor to the combinational one-hot next-state table.
- Holds an N-state one-hot state register and advances it on a step strobe through a next-state table.
- The next-state table is writable at run time; reset reloads a default rotation.
- Adds a direct-load path, sticky error detection for illegal inputs, a lap pulse and a saturating step counter.
- Sits between the design's control inputs and the output decoders, replacing the fixed lookup.

Parameters:
- N, 5, number of states; state vector width. Legal range 2..16.
- START, 0, index of the reset/recovery state; must be < N.
- CW, 8, width of the step counter.
- IW (localparam), $clog2(N), width of a state index.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- step  input  1  advance one transition this cycle.
- load  input  1  force state to load_state this cycle; has priority over step.
- load_state  input  N  one-hot value for load.
- tbl_we  input  1  write one next-state table entry.
- tbl_addr  input  IW  table entry (current-state index) to write.
- tbl_data  input  IW  successor index to store.
- err_clr  input  1  clear sticky err.
- state  output  N  current one-hot state (registered).
- state_idx  output  IW  binary index of state (combinational encode of the register).
- lap  output  1  one-cycle pulse, registered.
- err  output  1  sticky error flag.
- step_cnt  output  CW  steps taken since reset or last load; saturating.

Behaviour:
- Reset (async on rst_n low, released synchronously to clk):
  - state = one-hot bit START; err = 0; lap = 0; step_cnt = 0.
  - Table entry i = (i+1) mod N for all i.
- Table: N entries of IW bits in flops, no RAM.
  - tbl_we with tbl_addr < N writes the entry at the clock edge.
  - tbl_we with tbl_addr >= N is ignored and sets err.
  - A write and a step from the same entry in the same cycle: the step uses the OLD entry; the new value is seen from the next cycle.
- Per-cycle priority: load > step > hold.
- load:
  - If load_state is exactly one-hot, state <= load_state.
  - Otherwise (zero bits or more than one bit set), state <= one-hot START and err <= 1.
  - step_cnt <= 0; lap <= 0.
  - Any simultaneous step is discarded.
- step (with no load):
  - nxt = table[state_idx].
  - If nxt < N: state <= one-hot nxt.
  - If nxt >= N: state <= one-hot START and err <= 1.
  - lap <= 1 when the resulting state is START, otherwise 0.
  - step_cnt increments and saturates at 2^CW-1, with no wrap.
- Hold (neither load nor step): state and step_cnt unchanged; lap <= 0.
- lap is high for exactly one cycle per qualifying step. Back-to-back qualifying steps give back-to-back pulses.
- err:
  - Set by any illegal event above.
  - Cleared by err_clr only when no set event occurs in the same cycle; set wins.
  - err never changes state beyond the recovery described above.
- state is always exactly one-hot. No sequence of inputs may produce zero bits or more than one bit set.
- Reset asserted mid-operation returns everything, including the table, to reset values immediately.

Test Plan:
- Default rotation, N=5: release reset, then step 5 times.
  - state goes 00001, 00010, 00100, 01000, 10000, 00001.
  - lap pulses only on the 5th step; step_cnt=5; err=0.
- Table program:
  - Write entry 0 -> 3 and entry 3 -> 1, then step from reset.
  - state goes 00001, 01000, 00010.
  - Step on the same cycle as a write to entry 0 uses the old value.
- Load and priority:
  - load=1, step=1, load_state=00100 -> state=00100, step_cnt=0.
  - load_state=00110 -> state=00001, err=1.
  - err_clr with no set event -> err=0.
  - err_clr in the same cycle as an illegal load -> err stays 1.
- Out-of-range entries:
  - Write entry 2 -> 7 (IW=3), load 00100, step -> state=00001, err=1, lap=1.
  - tbl_we with tbl_addr=6 -> table unchanged, err=1.
- Saturation, CW=3: 10 steps -> step_cnt holds at 7.
- Async reset mid-run: assert rst_n low between clock edges after reprogramming.
  - Outputs reset without waiting for clk.
  - After release, stepping follows the default rotation.

Source files
------------

// File: rtl/onehot_seq_fsm.sv
// One-hot sequencer: an N-state one-hot register stepped through a run-time
// writable next-state table, with direct load, sticky error, lap pulse and step counter.
module onehot_seq_fsm #(
  parameter  int N     = 5,
  parameter  int START = 0,
  parameter  int CW    = 8,
  localparam int IW    = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  input  logic          load,
  input  logic [N-1:0]  load_state,
  input  logic          tbl_we,
  input  logic [IW-1:0] tbl_addr,
  input  logic [IW-1:0] tbl_data,
  input  logic          err_clr,
  output logic [N-1:0]  state,
  output logic [IW-1:0] state_idx,
  output logic          lap,
  output logic          err,
  output logic [CW-1:0] step_cnt
);
  localparam logic [N-1:0] START_OH = N'(1) << START;

  logic [N-1:0]  state_q, state_d;
  logic [IW-1:0] tbl_q [N];
  logic [IW-1:0] idx, nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lap_q, lap_d, err_q, err_d;
  logic          set_err, ld_ok, wr_ok;

  // state_q is always one-hot, so OR-reduction doubles as encoder and table mux
  always_comb begin
    idx = '0;
    nxt = '0;
    for (int i = 0; i < N; i++) begin
      if (state_q[i]) begin
        idx = idx | IW'(i);
        nxt = nxt | tbl_q[i];
      end
    end
  end

  assign ld_ok = (load_state != '0) && ((load_state & (load_state - 1'b1)) == '0);
  assign wr_ok = int'(tbl_addr) < N;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lap_d   = 1'b0;
    set_err = 1'b0;
    if (load) begin
      if (ld_ok) begin
        state_d = load_state;
      end else begin
        state_d = START_OH;
        set_err = 1'b1;
      end
      cnt_d = '0;
    end else if (step) begin
      if (int'(nxt) < N) begin
        state_d = N'(1) << nxt;
      end else begin
        state_d = START_OH;
        set_err = 1'b1;
      end
      lap_d = (state_d == START_OH);
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
    if (tbl_we && !wr_ok) set_err = 1'b1;
    err_d = set_err ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  // Table write lands at the edge, so a same-cycle step still reads the old entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= START_OH;
      cnt_q   <= '0;
      lap_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < N; i++) tbl_q[i] <= IW'((i + 1) % N);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lap_q   <= lap_d;
      err_q   <= err_d;
      for (int i = 0; i < N; i++)
        if (tbl_we && wr_ok && tbl_addr == IW'(i)) tbl_q[i] <= tbl_data;
    end
  end

  assign state     = state_q;
  assign state_idx = idx;
  assign lap       = lap_q;
  assign err       = err_q;
  assign step_cnt  = cnt_q;
endmodule

// File: tb/tb_onehot_seq_fsm.sv
// Bench for onehot_seq_fsm (N=5, CW=3): directed scenarios plus randomized
// traffic, all checked against an index/array level reference model.
module tb_onehot_seq_fsm;
  localparam int N     = 5;
  localparam int START = 0;
  localparam int CW    = 3;
  localparam int IW    = 3;
  localparam int MAXC  = 7;
  localparam int VW    = N + IW + 1 + 1 + CW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          step, load, tbl_we, err_clr;
  logic [N-1:0]  load_state;
  logic [IW-1:0] tbl_addr, tbl_data;
  logic [N-1:0]  state;
  logic [IW-1:0] state_idx;
  logic          lap, err;
  logic [CW-1:0] step_cnt;

  int tests = 0;
  int fails = 0;

  // reference model
  int m_idx, m_cnt;
  int m_tbl [N];
  bit m_lap, m_err;

  onehot_seq_fsm #(.N(N), .START(START), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .step(step), .load(load), .load_state(load_state),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data), .err_clr(err_clr),
    .state(state), .state_idx(state_idx), .lap(lap), .err(err), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  function automatic logic [VW-1:0] exp_vec();
    logic [N-1:0] s;
    s = '0;
    s[m_idx] = 1'b1;
    return {s, IW'(m_idx), m_lap, m_err, CW'(m_cnt)};
  endfunction

  function automatic logic [VW-1:0] got_vec();
    return {state, state_idx, lap, err, step_cnt};
  endfunction

  task automatic model_reset();
    m_idx = START;
    m_cnt = 0;
    m_lap = 0;
    m_err = 0;
    for (int i = 0; i < N; i++) m_tbl[i] = (i + 1) % N;
  endtask

  // Drive one cycle of inputs, clock it, advance the model, settle past the edge.
  task automatic do_cycle(input bit ist, input bit ild, input logic [N-1:0] ils,
                          input bit iwe, input logic [IW-1:0] iad,
                          input logic [IW-1:0] ida, input bit iclr);
    bit set;
    int n;
    step = ist; load = ild; load_state = ils;
    tbl_we = iwe; tbl_addr = iad; tbl_data = ida; err_clr = iclr;
    @(posedge clk);
    set = 0;
    if (ild) begin
      if ($countones(ils) == 1) begin
        for (int i = 0; i < N; i++) if (ils[i]) m_idx = i;
      end else begin
        m_idx = START;
        set = 1;
      end
      m_cnt = 0;
      m_lap = 0;
    end else if (ist) begin
      n = m_tbl[m_idx];
      if (n < N) m_idx = n;
      else begin
        m_idx = START;
        set = 1;
      end
      m_lap = (m_idx == START);
      m_cnt = (m_cnt >= MAXC) ? MAXC : m_cnt + 1;
    end else begin
      m_lap = 0;
    end
    if (iwe) begin
      if (int'(iad) < N) m_tbl[int'(iad)] = int'(ida);
      else set = 1;
    end
    m_err = set ? 1'b1 : (iclr ? 1'b0 : m_err);
    #1;
    step = 0; load = 0; tbl_we = 0; err_clr = 0;
  endtask

  task automatic test_reset();
    tests++;
    if (got_vec() !== {5'b00001, 3'd0, 1'b0, 1'b0, 3'd0}) begin
      fails++;
      $display("FAIL reset: got %h required %h", got_vec(), {5'b00001, 3'd0, 1'b0, 1'b0, 3'd0});
    end
  endtask

  task automatic test_default_rotation();
    logic [N-1:0] seq [5];
    seq = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    for (int k = 0; k < 5; k++) begin
      do_cycle(1, 0, '0, 0, '0, '0, 0);
      tests++;
      if (state !== seq[k] || lap !== (k == 4) || err !== 1'b0 || step_cnt !== CW'(k + 1)) begin
        fails++;
        $display("FAIL rotation step %0d: state %b lap %b err %b cnt %0d required %b %b 0 %0d",
                 k + 1, state, lap, err, step_cnt, seq[k], (k == 4), k + 1);
      end
    end
  endtask

  task automatic test_table_program();
    do_cycle(0, 0, '0, 1, 3'd0, 3'd3, 0);
    do_cycle(0, 0, '0, 1, 3'd3, 3'd1, 0);
    do_cycle(1, 0, '0, 0, '0, '0, 0);
    tests++;
    if (state !== 5'b01000 || got_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL tbl_step1: got %h required %h", got_vec(), exp_vec());
    end
    do_cycle(1, 0, '0, 0, '0, '0, 0);
    tests++;
    if (state !== 5'b00010 || got_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL tbl_step2: got %h required %h", got_vec(), exp_vec());
    end
    // step and rewrite of the same entry together: old successor is used
    do_cycle(0, 1, 5'b00001, 0, '0, '0, 0);
    do_cycle(1, 0, '0, 1, 3'd0, 3'd2, 0);
    tests++;
    if (state !== 5'b01000 || got_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL tbl_same_cycle: got %h required %h", got_vec(), exp_vec());
    end
    do_cycle(0, 1, 5'b00001, 0, '0, '0, 0);
    do_cycle(1, 0, '0, 0, '0, '0, 0);
    tests++;
    if (state !== 5'b00100 || got_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL tbl_new_value: got %h required %h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_load_priority();
    do_cycle(1, 1, 5'b00100, 0, '0, '0, 0);
    tests++;
    if (state !== 5'b00100 || step_cnt !== 3'd0 || got_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL load_over_step: got %h required %h", got_vec(), exp_vec());
    end
    do_cycle(0, 1, 5'b00110, 0, '0, '0, 0);
    tests++;
    if (state !== 5'b00001 || err !== 1'b1 || got_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL load_multi_hot: got %h required %h", got_vec(), exp_vec());
    end
    do_cycle(0, 0, '0, 0, '0, '0, 1);
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_clr: got %b required 0", err);
    end
    do_cycle(0, 1, 5'b00110, 0, '0, '0, 1);
    tests++;
    if (err !== 1'b1 || state !== 5'b00001) begin
      fails++;
      $display("FAIL set_beats_clr: err %b state %b required 1 00001", err, state);
    end
    do_cycle(0, 0, '0, 0, '0, '0, 1);
    do_cycle(0, 1, 5'b00000, 0, '0, '0, 0);
    tests++;
    if (err !== 1'b1 || got_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL load_zero: got %h required %h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_out_of_range();
    do_cycle(0, 0, '0, 0, '0, '0, 1);
    do_cycle(0, 0, '0, 1, 3'd2, 3'd7, 0);
    do_cycle(0, 1, 5'b00100, 0, '0, '0, 0);
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL oor_value_write: err %b required 0", err);
    end
    do_cycle(1, 0, '0, 0, '0, '0, 0);
    tests++;
    if (state !== 5'b00001 || err !== 1'b1 || lap !== 1'b1 || got_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL oor_successor: got %h required %h", got_vec(), exp_vec());
    end
    do_cycle(0, 0, '0, 0, '0, '0, 1);
    do_cycle(0, 0, '0, 1, 3'd6, 3'd0, 0);
    tests++;
    if (err !== 1'b1 || lap !== 1'b0 || got_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL oor_addr: got %h required %h", got_vec(), exp_vec());
    end
    // walk the whole table so an errant write would show up
    for (int k = 0; k < 6; k++) begin
      do_cycle(1, 0, '0, 0, '0, '0, 0);
      tests++;
      if (got_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL oor_table_walk %0d: got %h required %h", k, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_saturation();
    do_cycle(0, 1, 5'b00001, 0, '0, '0, 1);
    for (int k = 1; k <= 10; k++) begin
      do_cycle(1, 0, '0, 0, '0, '0, 0);
      tests++;
      if (step_cnt !== CW'((k > MAXC) ? MAXC : k) || got_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL saturation step %0d: cnt %0d required %0d", k, step_cnt,
                 (k > MAXC) ? MAXC : k);
      end
    end
  endtask

  task automatic test_random();
    bit ist, ild, iwe, iclr;
    logic [N-1:0] ils;
    logic [IW-1:0] iad, ida;
    for (int k = 0; k < 300; k++) begin
      ist  = ($urandom_range(0, 3) != 0);
      ild  = ($urandom_range(0, 7) == 0);
      ils  = ($urandom_range(0, 1) != 0) ? (N'(1) << $urandom_range(0, N - 1)) : N'($urandom);
      iwe  = ($urandom_range(0, 3) == 0);
      iad  = IW'($urandom_range(0, 7));
      ida  = ($urandom_range(0, 5) == 0) ? IW'($urandom_range(5, 7)) : IW'($urandom_range(0, N - 1));
      iclr = ($urandom_range(0, 3) == 0);
      do_cycle(ist, ild, ils, iwe, iad, ida, iclr);
      tests++;
      if (got_vec() !== exp_vec() || $countones(state) != 1) begin
        fails++;
        $display("FAIL random cycle %0d: got %h required %h", k, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    do_cycle(0, 0, '0, 1, 3'd0, 3'd3, 0);
    do_cycle(0, 1, 5'b00110, 0, '0, '0, 0);
    do_cycle(1, 0, '0, 0, '0, '0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    tests++;
    if (got_vec() !== {5'b00001, 3'd0, 1'b0, 1'b0, 3'd0}) begin
      fails++;
      $display("FAIL async_reset: got %h required %h", got_vec(), {5'b00001, 3'd0, 1'b0, 1'b0, 3'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_default_rotation();
  endtask

  initial begin
    rst_n = 1'b0;
    step = 0; load = 0; load_state = '0; tbl_we = 0;
    tbl_addr = '0; tbl_data = '0; err_clr = 0;
    model_reset();
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_default_rotation();
    test_table_program();
    test_load_priority();
    test_out_of_range();
    test_saturation();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
